// File: rtl/mac_ctrl_pkg.sv
// mac_ctrl_pkg
// Shared definitions for the MAC sequencing controller: controller state
// encoding, default pipeline depth and length-field width, and the widths of
// the MAC accumulator datapath (signed sum and maximum exponent) that this
// controller sequences.
package mac_ctrl_pkg;

  localparam int PIPE_DEPTH_DEF = 4;
  localparam int LEN_W_DEF      = 8;

  localparam int ACC_SUM_W = 20;
  localparam int ACC_EXP_W = 6;

  typedef logic signed [ACC_SUM_W-1:0] acc_sum_t;
  typedef logic        [ACC_EXP_W-1:0] acc_exp_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FEED,
    ST_DRAIN,
    ST_HOLD
  } mac_state_e;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// mac_seq_ctrl_if
// Handshake and datapath-control bundle between the MAC sequencing
// controller and its environment.
//   start/len          : pass request and operand-pair count
//   in_valid/in_ready  : upstream operand-pair handshake
//   stage_en           : advance enable for every MAC pipeline register
//   acc_clr/acc_en     : accumulator clear and capture strobes
//   out_valid/out_ready: downstream result handshake
//   busy/done          : controller status
// master: environment side, slave: controller side.
interface mac_seq_ctrl_if
  import mac_ctrl_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
);

  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic             stage_en;
  logic             acc_clr;
  logic             acc_en;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;

  modport master (
    output start, len, in_valid, out_ready,
    input  in_ready, stage_en, acc_clr, acc_en, out_valid, busy, done
  );

  modport slave (
    input  start, len, in_valid, out_ready,
    output in_ready, stage_en, acc_clr, acc_en, out_valid, busy, done
  );

endinterface

// File: rtl/mac_vld_pipe.sv
// mac_vld_pipe
// Valid-bit shadow of the MAC pipeline: one bit per pipeline stage telling
// whether that stage holds a real operand beat or a bubble.
//   clk, rst : clock and synchronous active-high reset
//   en       : pipeline advance enable (shift only when set)
//   din      : beat accepted into stage 0 this cycle
//   vld      : current valid bit of every stage, vld[PIPE_DEPTH-1] is last
module mac_vld_pipe
  import mac_ctrl_pkg::*;
#(
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  din,
  output logic [PIPE_DEPTH-1:0] vld
);

  logic [PIPE_DEPTH-1:0] vld_q;
  logic [PIPE_DEPTH-1:0] vld_d;

  always_comb begin
    vld_d = vld_q;
    if (en) begin
      vld_d = {vld_q[PIPE_DEPTH-2:0], din};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign vld = vld_q;

endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl
// Sequences one dot-product pass through a fixed-latency MAC pipeline:
// clears the accumulator, feeds len operand pairs, drains the pipeline,
// then holds the result until downstream takes it.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of mac_seq_ctrl_if (start/len, operand and result
//              handshakes, stage_en, acc_clr, acc_en, busy, done)
module mac_seq_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEF,
  parameter int LEN_W      = LEN_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  mac_seq_ctrl_if.slave  bus
);

  mac_state_e            state_q, state_d;
  logic [LEN_W:0]        cnt_q, cnt_d;
  logic [LEN_W:0]        cnt_inc;
  logic [LEN_W-1:0]      len_q, len_d;
  logic                  done_q, done_d;
  logic [PIPE_DEPTH-1:0] vld;
  logic                  beat;
  logic                  in_ready;
  logic                  stage_en;
  logic                  acc_clr;
  logic                  out_valid;

  // One extra counter bit so a maximum-length pass never wraps.
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    done_d    = 1'b0;
    in_ready  = 1'b0;
    stage_en  = 1'b0;
    acc_clr   = 1'b0;
    out_valid = 1'b0;
    beat      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          acc_clr = 1'b1;
          cnt_d   = '0;
          len_d   = bus.len;
          // An empty pass skips straight to presenting the cleared sum.
          state_d = (bus.len != '0) ? ST_FEED : ST_HOLD;
        end
      end
      ST_FEED: begin
        in_ready = 1'b1;
        stage_en = 1'b1;
        if (bus.in_valid) begin
          beat  = 1'b1;
          cnt_d = cnt_inc;
          if (cnt_inc == {1'b0, len_q}) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        stage_en = 1'b1;
        // Last beat reaches the accumulator and nothing is behind it.
        if (vld[PIPE_DEPTH-1] && (vld[PIPE_DEPTH-2:0] == '0)) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Strobes stay quiet while reset is asserted, whatever the old state.
    if (rst) begin
      in_ready  = 1'b0;
      stage_en  = 1'b0;
      acc_clr   = 1'b0;
      out_valid = 1'b0;
      beat      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      done_q  <= done_d;
    end
  end

  mac_vld_pipe #(
    .PIPE_DEPTH (PIPE_DEPTH)
  ) u_vld_pipe (
    .clk (clk),
    .rst (rst),
    .en  (stage_en),
    .din (beat),
    .vld (vld)
  );

  assign bus.in_ready  = in_ready;
  assign bus.stage_en  = stage_en;
  assign bus.acc_clr   = acc_clr;
  assign bus.acc_en    = vld[PIPE_DEPTH-1] & stage_en;
  assign bus.out_valid = out_valid;
  assign bus.busy      = (state_q != ST_IDLE) & ~rst;
  assign bus.done      = done_q & ~rst;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl
// Directed and randomized passes through mac_seq_ctrl. Expected per-cycle
// outputs of each pass are derived from the pass rules: which cycles accept
// a beat, when each beat reaches the accumulator, and how long the result is
// held. Inputs that should have no effect are randomized around them.
module tb_mac_seq_ctrl;

  localparam int PD  = 4;
  localparam int LW  = 8;
  localparam int MAXC = 2048;

  logic clk;
  logic rst;

  int n_vec;
  int n_err;
  int cyc;

  bit iv_pat [0:MAXC-1];
  bit e_ir   [0:MAXC-1];
  bit e_se   [0:MAXC-1];
  bit e_clr  [0:MAXC-1];
  bit e_ae   [0:MAXC-1];
  bit e_ov   [0:MAXC-1];
  bit e_busy [0:MAXC-1];
  bit e_done [0:MAXC-1];

  mac_seq_ctrl_if #(.LEN_W(LW)) bus ();

  mac_seq_ctrl #(
    .PIPE_DEPTH (PD),
    .LEN_W      (LW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input bit st, input bit [LW-1:0] ln,
                               input bit iv, input bit ordy, input bit rs);
    bus.start     = st;
    bus.len       = ln;
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    rst           = rs;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input bit ir, input bit se,
                          input bit clr, input bit ae, input bit ov,
                          input bit bsy, input bit dn);
    checkOutput({tag, ".in_ready"},  32'(bus.in_ready),  32'(ir));
    checkOutput({tag, ".stage_en"},  32'(bus.stage_en),  32'(se));
    checkOutput({tag, ".acc_clr"},   32'(bus.acc_clr),   32'(clr));
    checkOutput({tag, ".acc_en"},    32'(bus.acc_en),    32'(ae));
    checkOutput({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    checkOutput({tag, ".busy"},      32'(bus.busy),      32'(bsy));
    checkOutput({tag, ".done"},      32'(bus.done),      32'(dn));
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic fillIv(input bit all_ones);
    for (int i = 0; i < MAXC; i++) begin
      iv_pat[i] = all_ones ? 1'b1 : (($urandom % 4) != 0);
    end
  endtask

  // One pass starting in relative cycle 0 from IDLE. The expected waveform
  // comes from the pass rules: cycles 1.. are FEED until len beats are
  // accepted, each beat lands in the accumulator PD cycles later, the result
  // is held from the cycle after the last landing, and done follows the
  // out_ready cycle.
  task automatic runPass(input string tag, input int plen, input int wait_cyc,
                         input bit noise);
    int cnt;
    int r;
    int last;
    int h;
    int end_c;
    bit st;
    bit ordy;
    bit [LW-1:0] ln;
    for (int i = 0; i < MAXC; i++) begin
      e_ir[i] = 0; e_se[i] = 0; e_clr[i] = 0; e_ae[i] = 0;
      e_ov[i] = 0; e_busy[i] = 0; e_done[i] = 0;
    end
    cnt  = 0;
    r    = 1;
    last = 0;
    while (cnt < plen && r < MAXC - 64) begin
      e_ir[r] = 1;
      e_se[r] = 1;
      if (iv_pat[r]) begin
        cnt++;
        e_ae[r + PD] = 1;
        last = r;
      end
      r++;
    end
    if (plen == 0) begin
      h = 1;
    end else begin
      for (int q = last + 1; q <= last + PD; q++) e_se[q] = 1;
      h = last + PD + 1;
    end
    e_clr[0] = 1;
    for (int q = 1; q <= h + wait_cyc; q++) e_busy[q] = 1;
    for (int q = h; q <= h + wait_cyc; q++) e_ov[q] = 1;
    end_c = h + wait_cyc + 1;
    e_done[end_c] = 1;

    for (int k = 0; k <= end_c; k++) begin
      st   = 1'b0;
      ln   = LW'($urandom);
      ordy = 1'b0;
      if (k == 0) begin
        st = 1'b1;
        ln = LW'(plen);
      end else if (noise && k <= h + wait_cyc) begin
        st = 1'($urandom);
      end
      if (k >= h && k < h + wait_cyc) ordy = 1'b0;
      else if (k == h + wait_cyc)     ordy = 1'b1;
      else if (noise)                 ordy = 1'($urandom);
      applyStimulus(st, ln, iv_pat[k], ordy, 1'b0);
      @(negedge clk);
      checkAll(tag, e_ir[k], e_se[k], e_clr[k], e_ae[k], e_ov[k], e_busy[k], e_done[k]);
      nextCycle();
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    applyStimulus(1'b1, 8'd7, 1'b1, 1'b1, 1'b1);
    #1;

    // Reset with every input active: nothing may respond.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 8'd7, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      checkAll("reset", 0, 0, 0, 0, 0, 0, 0);
      nextCycle();
    end
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkAll("post_reset", 0, 0, 0, 0, 0, 0, 0);
    checkOutput("post_reset.vld", 32'(dut.vld), 32'd0);
    nextCycle();

    // len=3, in_valid held high.
    fillIv(1'b1);
    runPass("len3_full", 3, 0, 1'b0);

    // len=3 with an in_valid gap in cycle 2.
    fillIv(1'b1);
    iv_pat[2] = 1'b0;
    runPass("len3_gap", 3, 0, 1'b0);

    // Empty pass goes straight to the result.
    fillIv(1'b1);
    runPass("len0", 0, 0, 1'b0);

    // Result held while downstream stalls for 5 cycles.
    fillIv(1'b1);
    runPass("hold5", 2, 5, 1'b0);

    // start/len/out_ready/in_valid toggling where they must be ignored.
    fillIv(1'b1);
    runPass("ignore_start", 4, 3, 1'b1);

    // Reset after the second accepted beat of a len=5 pass.
    applyStimulus(1'b1, 8'd5, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkAll("rst_mid.c0", 0, 0, 1, 0, 0, 0, 0);
    nextCycle();
    for (int k = 1; k <= 2; k++) begin
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      checkAll("rst_mid.feed", 1, 1, 0, 0, 0, 1, 0);
      nextCycle();
    end
    applyStimulus(1'b1, 8'd9, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checkAll("rst_mid.rst", 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkAll("rst_mid.after", 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_mid.vld", 32'(dut.vld), 32'd0);
    nextCycle();
    fillIv(1'b1);
    runPass("rst_mid.restart", 2, 1, 1'b0);

    // Maximum length completes without counter wrap.
    fillIv(1'b1);
    runPass("len_max", (1 << LW) - 1, 0, 1'b0);

    // Randomized passes.
    for (int p = 0; p < 30; p++) begin
      fillIv(1'b0);
      runPass("rand", (($urandom % 8) == 0) ? 0 : int'($urandom_range(1, 24)),
              int'($urandom_range(0, 4)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
